trap_pc_ctrl: RTL and testbench

Trap and PC-source sequencer for the RV32 interrupt-capable core. It owns the `pc_src` select of the next-PC mux and runs a small FSM that decides, each cycle, between reset hold, trap entry, return-from-trap (mret) and normal fetch. It also generates the pipeline flush, `mepc`/`mcause` write strobes and MIE clear/restore strobes for the CSR file. It sits between the WB stage, the interrupt source and the next-PC mux, and is the only block allowed to drive `pc_src`.

---
 rtl/trap_pc_ctrl.sv | 138 +++++++++++++
 tb/tb_trap_pc_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_pc_ctrl.sv
// Trap / PC-source sequencer: owns the next-PC mux select and sequences reset hold,
// trap entry, mret return and post-redirect drain, with CSR write strobes.
module trap_pc_ctrl #(
   parameter int unsigned RESET_HOLD_CYCLES = 2,
   parameter int unsigned DRAIN_CYCLES      = 3
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_irq_pending,
   input  logic        i_mie_global,
   input  logic        i_exception,
   input  logic [4:0]  i_exc_cause,
   input  logic        i_mret,
   input  logic        i_wb_valid,
   input  logic [31:0] i_wb_pc,
   input  logic        i_hazard_full,
   input  logic        i_restore_pc,
   output logic [1:0]  o_pc_src,
   output logic        o_flush,
   output logic        o_mepc_we,
   output logic [31:0] o_mepc,
   output logic        o_mcause_we,
   output logic [31:0] o_mcause,
   output logic        o_mie_clear,
   output logic        o_mie_restore,
   output logic        o_busy
);

   localparam int unsigned MAX_CNT = (RESET_HOLD_CYCLES > DRAIN_CYCLES) ?
                                     RESET_HOLD_CYCLES : DRAIN_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] HOLD_INIT  = CNT_W'(RESET_HOLD_CYCLES);
   localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      S_HOLD,
      S_RUN,
      S_TRAP,
      S_EPC,
      S_DRAIN
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [31:0]       mepc, mepc_nx;
   logic [31:0]       mcause, mcause_nx;
   logic              take_exc, take_mret, take_irq;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= S_HOLD;
         cnt    <= HOLD_INIT;
         mepc   <= '0;
         mcause <= '0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         mepc   <= mepc_nx;
         mcause <= mcause_nx;
      end
   end

   // Event priority: exception, then mret, then a qualified interrupt.
   assign take_exc  = i_exception & i_wb_valid;
   assign take_mret = i_mret & i_wb_valid;
   assign take_irq  = i_irq_pending & i_mie_global & i_wb_valid &
                      ~i_hazard_full & ~i_restore_pc;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      mepc_nx   = mepc;
      mcause_nx = mcause;
      unique case (state)
         S_HOLD: begin
            cnt_nx = cnt - CNT_ONE;
            if (cnt <= CNT_ONE) state_nx = S_RUN;
         end
         S_RUN: begin
            if (take_exc) begin
               state_nx  = S_TRAP;
               mepc_nx   = i_wb_pc;
               mcause_nx = {27'b0, i_exc_cause};
            end else if (take_mret) begin
               state_nx = S_EPC;
            end else if (take_irq) begin
               state_nx  = S_TRAP;
               mepc_nx   = i_wb_pc + 32'd4;
               mcause_nx = 32'h8000_000B;
            end
         end
         S_TRAP, S_EPC: begin
            state_nx = S_DRAIN;
            cnt_nx   = DRAIN_INIT;
         end
         S_DRAIN: begin
            cnt_nx = cnt - CNT_ONE;
            if (cnt <= CNT_ONE) state_nx = S_RUN;
         end
         default: state_nx = S_HOLD;
      endcase
   end

   always_comb begin
      o_pc_src      = 2'b11;
      o_flush       = 1'b0;
      o_mepc_we     = 1'b0;
      o_mcause_we   = 1'b0;
      o_mie_clear   = 1'b0;
      o_mie_restore = 1'b0;
      o_busy        = 1'b1;
      unique case (state)
         S_HOLD: begin
            o_pc_src = 2'b00;
            o_flush  = 1'b1;
         end
         S_RUN: o_busy = 1'b0;
         S_TRAP: begin
            o_pc_src    = 2'b01;
            o_flush     = 1'b1;
            o_mepc_we   = 1'b1;
            o_mcause_we = 1'b1;
            o_mie_clear = 1'b1;
         end
         S_EPC: begin
            o_pc_src      = 2'b10;
            o_flush       = 1'b1;
            o_mie_restore = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_mepc   = mepc;
   assign o_mcause = mcause;

endmodule

// File: tb/tb_trap_pc_ctrl.sv
// Bench for trap_pc_ctrl: directed stimulus, literal spot checks and a per-cycle
// comparison against a countdown-based behavioural model.
module tb_trap_pc_ctrl;

   localparam int RH = 2;
   localparam int DR = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        irq = 1'b0, mie = 1'b0, exc = 1'b0, mret = 1'b0;
   logic        wbv = 1'b0, haz = 1'b0, rpc = 1'b0;
   logic [4:0]  cause = '0;
   logic [31:0] wbpc = '0;
   logic [1:0]  pc_src;
   logic        flush, mepc_we, mcause_we, mie_clear, mie_restore, busy;
   logic [31:0] mepc, mcause;

   int tests = 0;
   int fails = 0;

   trap_pc_ctrl #(.RESET_HOLD_CYCLES(RH), .DRAIN_CYCLES(DR)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_irq_pending(irq), .i_mie_global(mie),
      .i_exception(exc), .i_exc_cause(cause), .i_mret(mret), .i_wb_valid(wbv),
      .i_wb_pc(wbpc), .i_hazard_full(haz), .i_restore_pc(rpc),
      .o_pc_src(pc_src), .o_flush(flush), .o_mepc_we(mepc_we), .o_mepc(mepc),
      .o_mcause_we(mcause_we), .o_mcause(mcause), .o_mie_clear(mie_clear),
      .o_mie_restore(mie_restore), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: remaining hold cycles, a pending one-cycle redirect, remaining drain cycles.
   int          hold_left = RH;
   int          drain_left = 0;
   int          redir = 0;          // 0 none, 1 trap, 2 mret
   logic [31:0] m_mepc = '0, m_mcause = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_left  <= RH;
         drain_left <= 0;
         redir      <= 0;
         m_mepc     <= '0;
         m_mcause   <= '0;
      end else if (hold_left > 0) begin
         hold_left <= hold_left - 1;
      end else if (redir != 0) begin
         redir      <= 0;
         drain_left <= DR;
      end else if (drain_left > 0) begin
         drain_left <= drain_left - 1;
      end else if (exc && wbv) begin
         redir    <= 1;
         m_mepc   <= wbpc;
         m_mcause <= 32'(cause);
      end else if (mret && wbv) begin
         redir <= 2;
      end else if (irq && mie && wbv && !haz && !rpc) begin
         redir    <= 1;
         m_mepc   <= wbpc + 32'd4;
         m_mcause <= 32'h8000_000B;
      end
   end

   always @(negedge clk) begin
      logic [7:0] exp_v;
      if (hold_left > 0)       exp_v = {2'b00, 1'b1, 4'b0000, 1'b1};
      else if (redir == 1)     exp_v = {2'b01, 1'b1, 4'b1110, 1'b1};
      else if (redir == 2)     exp_v = {2'b10, 1'b1, 4'b0001, 1'b1};
      else if (drain_left > 0) exp_v = {2'b11, 1'b0, 4'b0000, 1'b1};
      else                     exp_v = {2'b11, 1'b0, 4'b0000, 1'b0};
      chk("model_outputs",
          {24'b0, pc_src, flush, mepc_we, mcause_we, mie_clear, mie_restore, busy},
          {24'b0, exp_v});
      if (hold_left > 0 || redir == 1) begin
         chk("model_mepc", mepc, m_mepc);
         chk("model_mcause", mcause, m_mcause);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_run_literal(input string name);
      for (int i = 0; i < DR; i++) begin
         tick();
         chk({name, "_drain_busy"}, 32'(busy), 32'd1);
         chk({name, "_drain_pcsrc"}, 32'(pc_src), 32'd3);
      end
      tick();
      chk({name, "_run_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic release_and_check_hold(input string name);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk({name, "_hold1"}, 32'(pc_src), 32'd0);
      chk({name, "_hold1_flush"}, 32'(flush), 32'd1);
      tick();
      chk({name, "_hold2"}, 32'(pc_src), 32'd0);
      tick();
      chk({name, "_run_pcsrc"}, 32'(pc_src), 32'd3);
      chk({name, "_run_flush"}, 32'(flush), 32'd0);
      chk({name, "_run_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_pcsrc", 32'(pc_src), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_mepc", mepc, 32'd0);
      chk("rst_mcause", mcause, 32'd0);
      release_and_check_hold("rel1");

      // Exception at 0x100, cause 2
      wbv = 1'b1; wbpc = 32'h100; exc = 1'b1; cause = 5'd2;
      tick();
      exc = 1'b0;
      chk("exc_pcsrc", 32'(pc_src), 32'd1);
      chk("exc_flush", 32'(flush), 32'd1);
      chk("exc_mepc", mepc, 32'h100);
      chk("exc_mcause", mcause, 32'h2);
      chk("exc_mie_clear", 32'(mie_clear), 32'd1);
      wait_run_literal("exc");

      // IRQ blocked by MIE=0, then by hazard, then accepted
      irq = 1'b1; mie = 1'b0; wbpc = 32'h200;
      repeat (3) begin tick(); chk("irq_mie0_pcsrc", 32'(pc_src), 32'd3); end
      mie = 1'b1; haz = 1'b1;
      repeat (2) begin tick(); chk("irq_haz_pcsrc", 32'(pc_src), 32'd3); end
      haz = 1'b0;
      tick();
      irq = 1'b0;
      chk("irq_pcsrc", 32'(pc_src), 32'd1);
      chk("irq_mepc", mepc, 32'h204);
      chk("irq_mcause", mcause, 32'h8000_000B);
      wait_run_literal("irq");

      // mret with IRQ pending: mret first, IRQ after drain
      irq = 1'b1; mret = 1'b1; wbpc = 32'h300;
      tick();
      mret = 1'b0; wbpc = 32'h304;
      chk("mret_pcsrc", 32'(pc_src), 32'd2);
      chk("mret_restore", 32'(mie_restore), 32'd1);
      chk("mret_no_clear", 32'(mie_clear), 32'd0);
      wait_run_literal("mret");
      tick();
      irq = 1'b0;
      chk("mret_irq_pcsrc", 32'(pc_src), 32'd1);
      chk("mret_irq_mepc", mepc, 32'h308);
      wait_run_literal("mret_irq");

      // Exception + IRQ + restore: exception wins; exception during drain ignored
      exc = 1'b1; cause = 5'd5; irq = 1'b1; rpc = 1'b1; wbpc = 32'h400;
      tick();
      irq = 1'b0; rpc = 1'b0; cause = 5'd7; wbpc = 32'h500;
      chk("exirq_pcsrc", 32'(pc_src), 32'd1);
      chk("exirq_mcause", mcause, 32'h5);
      chk("exirq_mepc", mepc, 32'h400);
      tick(); chk("drain_exc1", 32'(pc_src), 32'd3);
      tick(); chk("drain_exc2", 32'(pc_src), 32'd3);
      exc = 1'b0;
      tick(); chk("drain_exc3", 32'(pc_src), 32'd3);
      tick(); chk("drain_exc_run", 32'(busy), 32'd0);

      // mepc wraps modulo 2^32
      irq = 1'b1; wbpc = 32'hFFFF_FFFC;
      tick();
      irq = 1'b0;
      chk("wrap_mepc", mepc, 32'h0);
      chk("wrap_mcause", mcause, 32'h8000_000B);
      wait_run_literal("wrap");

      // Exception + mret: exception wins; exception without wb_valid ignored
      exc = 1'b1; mret = 1'b1; cause = 5'd4; wbpc = 32'h700;
      tick();
      exc = 1'b0; mret = 1'b0;
      chk("excmret_pcsrc", 32'(pc_src), 32'd1);
      chk("excmret_mcause", mcause, 32'h4);
      wait_run_literal("excmret");
      exc = 1'b1; wbv = 1'b0;
      tick();
      exc = 1'b0; wbv = 1'b1;
      chk("bubble_exc_pcsrc", 32'(pc_src), 32'd3);

      // Async reset during drain
      exc = 1'b1; cause = 5'd3; wbpc = 32'h600;
      tick();
      exc = 1'b0;
      chk("rd_trap_pcsrc", 32'(pc_src), 32'd1);
      tick();
      chk("rd_drain_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rd_pcsrc", 32'(pc_src), 32'd0);
      chk("rd_flush", 32'(flush), 32'd1);
      chk("rd_busy", 32'(busy), 32'd1);
      chk("rd_mepc", mepc, 32'd0);
      chk("rd_mcause", mcause, 32'd0);
      release_and_check_hold("rel2");

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
